// File: rtl/fetch_controller.sv
// Fetch-stage controller: sequences the PC register against an instruction
// memory with a req/ack handshake, drops responses made stale by a redirect,
// and buffers one instruction in a skid register while decode is stalled.
module fetch_controller #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          MAX_WAIT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcf,
  input  logic              pcsrce,
  input  logic              stalld,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              stallf,
  output logic              instr_valid,
  output logic [31:0]       instr_f,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              flushd,
  output logic              fetch_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

  state_t            state, state_nxt;
  logic              out_vld;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic [ADDR_W-1:0] disc_addr;
  logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
  logic              ld_mem, ld_skid, cap_skid, flush, latch_disc;

  assign flushd      = pcsrce;
  assign instr_valid = out_vld;
  assign instr_f     = out_vld ? out_instr : NOP_INSTR;
  assign instr_pc    = out_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs, stallf and data-steering strobes.
  // A redirect outranks everything: it frees the PC to load the target and
  // kills whatever this cycle would otherwise have captured.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    imem_addr  = pcf;
    stallf     = 1'b1;
    ld_mem     = 1'b0;
    ld_skid    = 1'b0;
    cap_skid   = 1'b0;
    flush      = 1'b0;
    latch_disc = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (pcsrce) begin
          stallf = 1'b0;
          flush  = 1'b1;
          // Request still in flight: remember its address so it stays stable
          // until the memory answers, then drop that answer.
          if (!imem_ack) begin
            latch_disc = 1'b1;
            state_nxt  = S_DISCARD;
          end
        end else if (imem_ack) begin
          if (stalld) begin
            cap_skid  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            stallf = 1'b0;
            ld_mem = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (pcsrce) begin
          stallf    = 1'b0;
          flush     = 1'b1;
          state_nxt = S_REQ;
        end else if (!stalld) begin
          stallf    = 1'b0;
          ld_skid   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = disc_addr;
        if (pcsrce) begin
          stallf = 1'b0;
          flush  = 1'b1;
        end else if (imem_ack) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // IF/ID output register: holds under decode stall, empties when consumed
  // with nothing new to present.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (ld_mem) begin
      out_vld   <= 1'b1;
      out_instr <= imem_rdata;
      out_pc    <= pcf;
    end else if (ld_skid) begin
      out_vld   <= 1'b1;
      out_instr <= skid_instr;
      out_pc    <= skid_pc;
    end else if (!stalld) begin
      out_vld <= 1'b0;
    end
  end

  // Skid buffer and stale-request address; contents only matter in HOLD /
  // DISCARD respectively.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      disc_addr  <= '0;
    end else begin
      if (cap_skid) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pcf;
      end
      if (latch_disc) disc_addr <= pcf;
    end
  end

  // Wait counter: saturating count of unanswered request cycles.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (imem_ack)                            wait_cnt_nxt = '0;
    else if (imem_req && wait_cnt != WAIT_MAX) wait_cnt_nxt = wait_cnt + 1'b1;
  end

  // Sticky timeout flag, raised in the same edge the counter hits the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == WAIT_MAX) fetch_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a PC register and a random-latency
// memory surround the DUT; a program-order scoreboard checks what decode sees.
module tb_fetch_controller;

  localparam int          AW   = 32;
  localparam int          MAXW = 4;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pcf;
  logic          pcsrce = 1'b0;
  logic          stalld = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          stallf;
  logic          instr_valid;
  logic [31:0]   instr_f;
  logic [AW-1:0] instr_pc;
  logic          flushd;
  logic          fetch_timeout;
  logic [AW-1:0] tgt = '0;

  int n_chk = 0;
  int n_err = 0;

  fetch_controller #(.ADDR_W(AW), .NOP_INSTR(NOP), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .pcf(pcf), .pcsrce(pcsrce), .stalld(stalld),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stallf(stallf), .instr_valid(instr_valid),
    .instr_f(instr_f), .instr_pc(instr_pc), .flushd(flushd),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  // PC register environment: holds on stallf, loads target on redirect.
  always @(posedge clk) begin
    if (rst)          pcf <= '0;
    else if (!stallf) pcf <= pcsrce ? tgt : pcf + 32'd4;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [31:0] exp_pc = '0;
  int          m_cnt = 0;
  logic        m_to = 1'b0;
  int          mwait = 0, mlat = 0;
  int          stuck = 0;
  logic        p_rst = 1'b1, p_wait = 1'b0, p_hold = 1'b0, p_redir = 1'b0;
  logic [31:0] p_addr = '0, p_pc = '0, p_instr = '0;

  // One clock cycle. ackm: 0 random memory, 1 ack every request,
  // 2 never ack, 3 ack held high regardless of request.
  task automatic cycle(input logic r, input int ackm, input bit rnd);
    @(posedge clk);
    #1;
    rst    = r;
    stalld = rnd ? ($urandom_range(0, 9) < 3) : 1'b0;
    pcsrce = (rnd && !r && !p_rst) ? ($urandom_range(0, 11) == 0) : 1'b0;
    tgt    = $urandom & 32'h0000_0FFC;
    if (ackm == 3)     imem_ack = 1'b1;
    else if (imem_req) imem_ack = (ackm == 1) || (ackm == 0 && mwait >= mlat);
    else               imem_ack = (ackm == 0) && ($urandom_range(0, 15) == 0);
    imem_rdata = (imem_req && imem_ack) ? memf(imem_addr) : $urandom;
    #1;

    chk("flushd", 32'(flushd), 32'(pcsrce));
    if (pcsrce)       chk("stallf_redirect", 32'(stallf), 32'd0);
    if (!instr_valid) chk("nop_when_invalid", instr_f, NOP);
    if (p_rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_stallf", 32'(stallf), 32'd1);
      chk("rst_instr", instr_f, NOP);
    end else begin
      if (p_wait) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, p_addr);
      end
      if (p_hold) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_pc", instr_pc, p_pc);
        chk("hold_instr", instr_f, p_instr);
      end
      if (p_redir) chk("redirect_clears", 32'(instr_valid), 32'd0);
    end
    if (instr_valid) chk("data", instr_f, memf(instr_pc));
    chk("timeout", 32'(fetch_timeout), 32'(m_to));

    stuck++;
    if (!r && instr_valid && !stalld && !pcsrce) begin
      chk("order", instr_pc, exp_pc);
      exp_pc = instr_pc + 32'd4;
      stuck = 0;
    end
    if (r || pcsrce || !rnd) stuck = 0;
    if (stuck > 64) begin
      chk("progress", 32'(stuck), 32'd64);
      stuck = 0;
    end

    // Advance the reference to the next edge
    if (r) begin
      exp_pc = '0; m_cnt = 0; m_to = 1'b0; mwait = 0;
    end else begin
      if (pcsrce) exp_pc = tgt;
      if (imem_ack)                    m_cnt = 0;
      else if (imem_req && m_cnt < MAXW) m_cnt++;
      if (m_cnt == MAXW) m_to = 1'b1;
      if (imem_req && imem_ack) begin
        mwait = 0;
        mlat  = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
      end else if (imem_req) mwait++;
    end
    p_rst   = r;
    p_wait  = imem_req && !imem_ack;
    p_addr  = imem_addr;
    p_hold  = instr_valid && stalld && !pcsrce;
    p_pc    = instr_pc;
    p_instr = instr_f;
    p_redir = pcsrce;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 1, 1'b0);

    // Zero-wait memory: one instruction per cycle from PC 0
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1, 1'b0);
      if (k == 0) chk("zw_idle_req", 32'(imem_req), 32'd0);
      if (k == 1) begin
        chk("zw_first_addr", imem_addr, 32'd0);
        chk("zw_first_stallf", 32'(stallf), 32'd0);
      end
      if (k >= 2) begin
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_pc", instr_pc, 32'(4 * (k - 2)));
        chk("zw_addr", imem_addr, 32'(4 * (k - 1)));
      end
    end

    // Timeout: memory silent long enough, then answers; flag stays until rst
    cycle(1'b1, 1, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 2, 1'b0);
    chk("timeout_set", 32'(fetch_timeout), 32'd1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1, 1'b0);
    chk("timeout_sticky", 32'(fetch_timeout), 32'd1);

    // Reset with an ack pending, then an ack while idle must be ignored
    cycle(1'b1, 1, 1'b0);
    cycle(1'b0, 3, 1'b0);
    chk("timeout_cleared", 32'(fetch_timeout), 32'd0);
    cycle(1'b0, 2, 1'b0);
    chk("late_ack_ignored", 32'(instr_valid), 32'd0);
    cycle(1'b0, 2, 1'b0);
    chk("late_ack_no_data", 32'(instr_valid), 32'd0);

    // Random traffic: latency, stalls, redirects, occasional reset
    cycle(1'b1, 0, 1'b0);
    for (int k = 0; k < 4000; k++)
      cycle(($urandom_range(0, 299) == 0), 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
